// File: rtl/proc_pkg.sv
// Shared types and constants for the 10-bit processor datapath controller.
// CTRL_SINGLE_STEP_EN (optional) gates TIME advances on a STEP rising edge.
package proc_pkg;

  localparam int DATA_W   = 10;
  localparam int NUM_REGS = 4;

  typedef logic [1:0] timestep_t;

  localparam timestep_t T0 = 2'd0;
  localparam timestep_t T1 = 2'd1;
  localparam timestep_t T2 = 2'd2;
  localparam timestep_t T3 = 2'd3;

  typedef enum logic [3:0] {
    OP_LOAD = 4'h0,
    OP_COPY = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_INV  = 4'h4,
    OP_ADDI = 4'h6,
    OP_SUBI = 4'h7
  } opcode_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_INV  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  function automatic logic [NUM_REGS-1:0] regOneHot(input logic [1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/control_unit_edge_detect.sv
// Registered rising-edge detector for debounced level inputs (EXEC, STEP).
module edge_detect (
  input  logic CLK,
  input  logic RSTb,
  input  logic D,
  output logic RISE
);

  logic dQ;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) dQ <= 1'b0;
    else       dQ <= D;
  end

  assign RISE = D & ~dQ;

endmodule

// File: rtl/control_unit.sv
// Timestep sequencer and Moore decoder for the 10-bit datapath.
// Optional build macro: CTRL_SINGLE_STEP_EN (adds STEP input, manual advance).
module control_unit
  import proc_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              EXEC,
  input  logic [DATA_W-1:0] INSTR,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              STEP,
`endif
  output logic [1:0]        TIME,
  output logic              DONE,
  output logic              ILLEGAL,
  output logic [3:0]        RIN,
  output logic [3:0]        ROUT,
  output logic              AIN,
  output logic              GIN,
  output logic              GOUT,
  output logic              EXTRN,
  output logic              IMM_OUT,
  output logic [1:0]        ALU_OP,
  output logic [DATA_W-1:0] IMM
);

  timestep_t         timeQ, timeD;
  logic [DATA_W-1:0] irQ, irD;
  logic              execRise;
  logic              advance;
  logic              doneS;
  logic              unusedIrLow;

  edge_detect uExecEdge (
    .CLK  (CLK),
    .RSTb (RSTb),
    .D    (EXEC),
    .RISE (execRise)
  );

`ifdef CTRL_SINGLE_STEP_EN
  logic stepRise;

  edge_detect uStepEdge (
    .CLK  (CLK),
    .RSTb (RSTb),
    .D    (STEP),
    .RISE (stepRise)
  );

  assign advance = stepRise;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      timeQ <= T0;
      irQ   <= '0;
    end else begin
      timeQ <= timeD;
      irQ   <= irD;
    end
  end

  // Starts are accepted only from T0, so edges mid-instruction are dropped.
  always_comb begin
    timeD = timeQ;
    irD   = irQ;
    if (timeQ == T0) begin
      if (execRise) begin
        irD   = INSTR;
        timeD = T1;
      end
    end else if (advance) begin
      timeD = doneS ? T0 : timeQ + 2'd1;
    end
  end

  always_comb begin
    logic [1:0] rx;
    logic [1:0] ry;
    logic [1:0] arith;
    rx      = irQ[5:4];
    ry      = irQ[3:2];
    arith   = irQ[6] ? ALU_SUB : ALU_ADD;
    RIN     = '0;
    ROUT    = '0;
    AIN     = 1'b0;
    GIN     = 1'b0;
    GOUT    = 1'b0;
    EXTRN   = 1'b0;
    IMM_OUT = 1'b0;
    ALU_OP  = ALU_ADD;
    doneS   = 1'b0;
    ILLEGAL = 1'b0;
    if (timeQ != T0) begin
      case (opcode_e'(irQ[9:6]))
        OP_LOAD: begin
          EXTRN = 1'b1;
          RIN   = regOneHot(rx);
          doneS = 1'b1;
        end
        OP_COPY: begin
          ROUT  = regOneHot(ry);
          RIN   = regOneHot(rx);
          doneS = 1'b1;
        end
        OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
          case (timeQ)
            T1: begin
              ROUT = regOneHot(rx);
              AIN  = 1'b1;
            end
            T2: begin
              if (irQ[8]) IMM_OUT = 1'b1;
              else        ROUT    = regOneHot(ry);
              GIN    = 1'b1;
              ALU_OP = arith;
            end
            default: begin
              GOUT  = 1'b1;
              RIN   = regOneHot(rx);
              doneS = 1'b1;
            end
          endcase
        end
        OP_INV: begin
          if (timeQ == T1) begin
            ROUT   = regOneHot(ry);
            GIN    = 1'b1;
            ALU_OP = ALU_INV;
          end else begin
            GOUT  = 1'b1;
            RIN   = regOneHot(rx);
            doneS = 1'b1;
          end
        end
        default: begin
          doneS   = 1'b1;
          ILLEGAL = 1'b1;
        end
      endcase
    end
  end

  assign TIME        = timeQ;
  assign DONE        = doneS;
  assign IMM         = {{(DATA_W-2){1'b0}}, irQ[3:2]};
  assign unusedIrLow = ^irQ[1:0];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table, corner sequences,
// and randomized traffic against a queue-based step model.
module tb_control_unit;

  logic       CLK;
  logic       RSTb;
  logic       EXEC;
  logic [9:0] INSTR;
`ifdef CTRL_SINGLE_STEP_EN
  logic       STEP;
`endif
  logic [1:0] TIME;
  logic       DONE, ILLEGAL, AIN, GIN, GOUT, EXTRN, IMM_OUT;
  logic [3:0] RIN, ROUT;
  logic [1:0] ALU_OP;
  logic [9:0] IMM;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .EXEC    (EXEC),
    .INSTR   (INSTR),
`ifdef CTRL_SINGLE_STEP_EN
    .STEP    (STEP),
`endif
    .TIME    (TIME),
    .DONE    (DONE),
    .ILLEGAL (ILLEGAL),
    .RIN     (RIN),
    .ROUT    (ROUT),
    .AIN     (AIN),
    .GIN     (GIN),
    .GOUT    (GOUT),
    .EXTRN   (EXTRN),
    .IMM_OUT (IMM_OUT),
    .ALU_OP  (ALU_OP),
    .IMM     (IMM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [18:0] outBus;
  assign outBus = {TIME, DONE, ILLEGAL, RIN, ROUT, AIN, GIN, GOUT, EXTRN, IMM_OUT, ALU_OP};

  localparam logic [18:0] IDLE = 19'b0;

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  function automatic logic [18:0] mk(input int t, input bit done, input bit ill,
                                     input logic [3:0] rin, input logic [3:0] rout,
                                     input bit ain, input bit gin, input bit gout,
                                     input bit extrn, input bit immOut,
                                     input logic [1:0] alu);
    logic [1:0] tt;
    tt = t[1:0];
    return {tt, done, ill, rin, rout, ain, gin, gout, extrn, immOut, alu};
  endfunction

  // Reference model: a start pushes the whole list of expected steps, each clock pops one.
  logic [18:0] mq[$];
  logic        prevExec = 1'b0;
  logic [9:0]  mIr = 10'd0;

  task automatic buildSteps(input logic [9:0] ins);
    logic [1:0] x, y;
    logic [1:0] arith;
    x = ins[5:4];
    y = ins[3:2];
    arith = ins[6] ? 2'b01 : 2'b00;
    case (ins[9:6])
      4'd0: mq.push_back(mk(1, 1, 0, oh(x), 4'b0, 0, 0, 0, 1, 0, 2'b00));
      4'd1: mq.push_back(mk(1, 1, 0, oh(x), oh(y), 0, 0, 0, 0, 0, 2'b00));
      4'd2, 4'd3: begin
        mq.push_back(mk(1, 0, 0, 4'b0, oh(x), 1, 0, 0, 0, 0, 2'b00));
        mq.push_back(mk(2, 0, 0, 4'b0, oh(y), 0, 1, 0, 0, 0, arith));
        mq.push_back(mk(3, 1, 0, oh(x), 4'b0, 0, 0, 1, 0, 0, 2'b00));
      end
      4'd4: begin
        mq.push_back(mk(1, 0, 0, 4'b0, oh(y), 0, 1, 0, 0, 0, 2'b10));
        mq.push_back(mk(2, 1, 0, oh(x), 4'b0, 0, 0, 1, 0, 0, 2'b00));
      end
      4'd6, 4'd7: begin
        mq.push_back(mk(1, 0, 0, 4'b0, oh(x), 1, 0, 0, 0, 0, 2'b00));
        mq.push_back(mk(2, 0, 0, 4'b0, 4'b0, 0, 1, 0, 0, 1, arith));
        mq.push_back(mk(3, 1, 0, oh(x), 4'b0, 0, 0, 1, 0, 0, 2'b00));
      end
      default: mq.push_back(mk(1, 1, 1, 4'b0, 4'b0, 0, 0, 0, 0, 0, 2'b00));
    endcase
  endtask

  always @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      mq.delete();
      prevExec = 1'b0;
      mIr = 10'd0;
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      else if (EXEC && !prevExec) begin
        mIr = INSTR;
        buildSteps(INSTR);
      end
      prevExec = EXEC;
    end
  end

  function automatic logic [18:0] modelBus();
    return (mq.size() > 0) ? mq[0] : IDLE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [9:0]       instr;
    int               n;
    logic [2:0][18:0] steps;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [9:0] ins, input int n,
                        input logic [18:0] s0, input logic [18:0] s1, input logic [18:0] s2);
    vec_t v;
    v.instr = ins;
    v.n = n;
    v.steps[0] = s0;
    v.steps[1] = s1;
    v.steps[2] = s2;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [9:0] ins);
    INSTR = ins;
    EXEC = 1'b1;
    tick();
    EXEC = 1'b0;
  endtask

  initial begin
    logic [9:0] expImm;
    RSTb = 1'b0;
    EXEC = 1'b0;
    INSTR = 10'd0;
`ifdef CTRL_SINGLE_STEP_EN
    STEP = 1'b0;
`endif
    #12;
    checkOutput("reset_bus", {13'b0, outBus}, 32'd0);
    checkOutput("reset_imm", {22'b0, IMM}, 32'd0);
    RSTb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("idle_%0d", i), {13'b0, outBus}, 32'd0);
    end

`ifdef CTRL_SINGLE_STEP_EN
    applyStimulus(10'b0010_10_11_00);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("ss_hold_t1_%0d", i), {13'b0, outBus},
                  {13'b0, mk(1, 0, 0, 4'b0, 4'b0100, 1, 0, 0, 0, 0, 2'b00)});
      tick();
    end
    STEP = 1'b1; tick();
    checkOutput("ss_t2", {13'b0, outBus}, {13'b0, mk(2, 0, 0, 4'b0, 4'b1000, 0, 1, 0, 0, 0, 2'b00)});
    tick();
    checkOutput("ss_t2_held", {13'b0, outBus}, {13'b0, mk(2, 0, 0, 4'b0, 4'b1000, 0, 1, 0, 0, 0, 2'b00)});
    STEP = 1'b0; tick();
    STEP = 1'b1; tick();
    checkOutput("ss_t3", {13'b0, outBus}, {13'b0, mk(3, 1, 0, 4'b0100, 4'b0, 0, 0, 1, 0, 0, 2'b00)});
    STEP = 1'b0; tick();
    checkOutput("ss_t3_held", {13'b0, outBus}, {13'b0, mk(3, 1, 0, 4'b0100, 4'b0, 0, 0, 1, 0, 0, 2'b00)});
    STEP = 1'b1; tick();
    checkOutput("ss_t0", {13'b0, outBus}, 32'd0);
    STEP = 1'b0; tick();
    STEP = 1'b1; tick();
    checkOutput("ss_t0_step_ignored", {13'b0, outBus}, 32'd0);
`else
    addVec(10'b0000_01_00_00, 1, mk(1, 1, 0, 4'b0010, 4'b0, 0, 0, 0, 1, 0, 2'b00), IDLE, IDLE);
    addVec(10'b0001_11_00_00, 1, mk(1, 1, 0, 4'b1000, 4'b0001, 0, 0, 0, 0, 0, 2'b00), IDLE, IDLE);
    addVec(10'b0010_10_11_00, 3, mk(1, 0, 0, 4'b0, 4'b0100, 1, 0, 0, 0, 0, 2'b00),
           mk(2, 0, 0, 4'b0, 4'b1000, 0, 1, 0, 0, 0, 2'b00),
           mk(3, 1, 0, 4'b0100, 4'b0, 0, 0, 1, 0, 0, 2'b00));
    addVec(10'b0011_01_01_00, 3, mk(1, 0, 0, 4'b0, 4'b0010, 1, 0, 0, 0, 0, 2'b00),
           mk(2, 0, 0, 4'b0, 4'b0010, 0, 1, 0, 0, 0, 2'b01),
           mk(3, 1, 0, 4'b0010, 4'b0, 0, 0, 1, 0, 0, 2'b00));
    addVec(10'b0100_00_10_00, 2, mk(1, 0, 0, 4'b0, 4'b0100, 0, 1, 0, 0, 0, 2'b10),
           mk(2, 1, 0, 4'b0001, 4'b0, 0, 0, 1, 0, 0, 2'b00), IDLE);
    addVec(10'b0110_11_10_00, 3, mk(1, 0, 0, 4'b0, 4'b1000, 1, 0, 0, 0, 0, 2'b00),
           mk(2, 0, 0, 4'b0, 4'b0, 0, 1, 0, 0, 1, 2'b00),
           mk(3, 1, 0, 4'b1000, 4'b0, 0, 0, 1, 0, 0, 2'b00));
    addVec(10'b0111_00_11_00, 3, mk(1, 0, 0, 4'b0, 4'b0001, 1, 0, 0, 0, 0, 2'b00),
           mk(2, 0, 0, 4'b0, 4'b0, 0, 1, 0, 0, 1, 2'b01),
           mk(3, 1, 0, 4'b0001, 4'b0, 0, 0, 1, 0, 0, 2'b00));
    addVec(10'b1010_00_00_00, 1, mk(1, 1, 1, 4'b0, 4'b0, 0, 0, 0, 0, 0, 2'b00), IDLE, IDLE);
    addVec(10'b0101_10_01_11, 1, mk(1, 1, 1, 4'b0, 4'b0, 0, 0, 0, 0, 0, 2'b00), IDLE, IDLE);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].instr);
      expImm = {8'b0, vecs[i].instr[3:2]};
      for (int s = 0; s < vecs[i].n; s++) begin
        checkOutput($sformatf("vec%0d_T%0d", i, s + 1), {13'b0, outBus}, {13'b0, vecs[i].steps[s]});
        checkOutput($sformatf("vec%0d_imm", i), {22'b0, IMM}, {22'b0, expImm});
        tick();
      end
      checkOutput($sformatf("vec%0d_back_to_T0", i), {13'b0, outBus}, 32'd0);
    end

    // A second EXEC edge mid-instruction must neither restart nor be queued.
    applyStimulus(10'b0010_10_11_00);
    tick();
    checkOutput("ign_T2", {13'b0, outBus}, {13'b0, mk(2, 0, 0, 4'b0, 4'b1000, 0, 1, 0, 0, 0, 2'b00)});
    INSTR = 10'b0000_01_00_00;
    EXEC = 1'b1;
    tick();
    checkOutput("ign_T3", {13'b0, outBus}, {13'b0, mk(3, 1, 0, 4'b0100, 4'b0, 0, 0, 1, 0, 0, 2'b00)});
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("held_exec_idle_%0d", i), {13'b0, outBus}, 32'd0);
    end
    EXEC = 1'b0; tick();
    EXEC = 1'b1; tick();
    checkOutput("restart_load_T1", {13'b0, outBus}, {13'b0, mk(1, 1, 0, 4'b0010, 4'b0, 0, 0, 0, 1, 0, 2'b00)});
    EXEC = 1'b0; tick();

    // Asynchronous reset in the middle of ADD must clear outputs without a clock.
    applyStimulus(10'b0010_10_11_00);
    tick();
    RSTb = 1'b0;
    #1;
    checkOutput("midreset_bus", {13'b0, outBus}, 32'd0);
    checkOutput("midreset_imm", {22'b0, IMM}, 32'd0);
    #2;
    RSTb = 1'b1;
    tick();
    checkOutput("after_midreset", {13'b0, outBus}, 32'd0);

    for (int c = 0; c < 600; c++) begin
      INSTR = 10'($urandom);
      EXEC = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        RSTb = 1'b0;
        #1;
        checkOutput($sformatf("rnd_reset_%0d", c), {13'b0, outBus}, 32'd0);
        RSTb = 1'b1;
      end
      tick();
      checkOutput($sformatf("rnd_bus_%0d", c), {13'b0, outBus}, {13'b0, modelBus()});
      checkOutput($sformatf("rnd_imm_%0d", c), {22'b0, IMM}, {30'b0, mIr[3:2]});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing controller for the 10-bit processor datapath. It latches an instruction on an EXEC rising edge and steps a 2-bit timestep counter (TIME, T0–T3). At each step it decodes the instruction into one-hot register load/drive strobes, ALU controls and bus-source selects. It drives the TIME and DONE signals consumed by the display/LED output stage.

## Interface
- No parameters; widths fixed by the shared package (10-bit data, 4 registers).
- CLK  in  1  system clock; all state changes on rising edge.
- RSTb  in  1  reset, asynchronous, active-low.
- EXEC  in  1  execute request (debounced level); acts on rising edge only.
- INSTR  in  10  instruction word: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored.
- STEP  in  1  manual advance (present only with CTRL_SINGLE_STEP_EN).
- TIME  out  2  current timestep.
- DONE  out  1  high during final step of an instruction.
- ILLEGAL  out  1  high with DONE when opcode is undefined.
- RIN  out  4  one-hot register load enable.
- ROUT  out  4  one-hot register drive-to-BUS.
- AIN, GIN, GOUT, EXTRN, IMM_OUT  out  1 each: A-latch load, G-latch load, G drives BUS, external data drives BUS, immediate drives BUS.
- ALU_OP  out  2  00 add, 01 sub, 10 invert B, 11 pass B.
- IMM  out  10  {8'b0, IR[3:2]}; valid whenever IMM_OUT high.

## Operation
- State: TIME counter, 10-bit IR, EXEC edge register. Control outputs are combinational decode of IR and TIME (Moore).
- T0 idle: all strobes low. EXEC high while edge register low → IR<=INSTR, TIME<=1. An EXEC edge in T1–T3 is ignored and not queued.
- Opcode sequences (x = IR[5:4], y = IR[3:2]); after the DONE step, TIME<=0:
  - 0000 LOAD: T1 EXTRN, RIN[x], DONE.
  - 0001 COPY: T1 ROUT[y], RIN[x], DONE.
  - 0010 ADD / 0011 SUB: T1 ROUT[x], AIN; T2 ROUT[y], GIN, ALU_OP=00/01; T3 GOUT, RIN[x], DONE.
  - 0100 INV: T1 ROUT[y], GIN, ALU_OP=10; T2 GOUT, RIN[x], DONE.
  - 0110 ADDI / 0111 SUBI: T1 ROUT[x], AIN; T2 IMM_OUT, GIN, ALU_OP=00/01; T3 GOUT, RIN[x], DONE.
  - 0101, 1000–1111 illegal: T1 DONE, ILLEGAL; no other strobes.
- Invariant: at most one of ROUT[*], GOUT, EXTRN, IMM_OUT high in any cycle. RIN never high with AIN or GIN.
- x == y is legal; e.g. ADD R1,R1 doubles R1.

## Timing
- Reset: TIME=0, IR=0, edge register=0. All outputs low; ALU_OP=00, IMM=0. Reset mid-instruction aborts immediately with no partial write.
- Latency: EXEC edge sampled at edge n → T1 strobes valid after edge n. An instruction of k steps returns to T0 after edge n+k.
- Back-to-back: the earliest next start is an EXEC rising edge sampled in T0. This requires EXEC to go low, then high again.
- DONE lasts exactly one step.

## Configuration
- CTRL_SINGLE_STEP_EN defined:
  - adds STEP input, with its own edge register;
  - the EXEC edge still starts T1, but each later TIME advance, including DONE→T0, occurs only on a STEP rising edge;
  - strobes hold for the whole step;
  - a STEP edge in T0 is ignored.
- Macro undefined: STEP port absent; TIME advances every clock once started.

## Structure
- Package proc_pkg holds:
  - opcode enum;
  - timestep_t (logic [1:0]);
  - ALU_OP constants;
  - DATA_W=10 and NUM_REGS=4.
- Sub-module edge_detect (CLK, RSTb, D, RISE) is used for EXEC and, if enabled, STEP.

## Test plan
- Reset release, EXEC low for 5 cycles → TIME=0, all strobes 0, DONE=0.
- INSTR=10'b0000_01_00_00, EXEC pulse → next cycle TIME=1, EXTRN=1, RIN=0010, DONE=1; following cycle TIME=0.
- INSTR=10'b0010_10_11_00 (ADD R2,R3) → T1 ROUT=0100,AIN; T2 ROUT=1000,GIN,ALU_OP=00; T3 GOUT,RIN=0100,DONE.
- INSTR=10'b0111_00_11_00 (SUBI R0,#3) → T2 IMM_OUT=1, IMM=10'd3, ALU_OP=01; T3 RIN=0001, DONE.
- INSTR=10'b1010_00_00_00 → T1 DONE=1, ILLEGAL=1, RIN=0; second EXEC edge during ADD T2 ignored, and EXEC held high never restarts.
- RSTb low during ADD T2 → all outputs 0 immediately. With CTRL_SINGLE_STEP_EN, ADD holds T1 across 20 clocks until a STEP edge moves it to T2.
